// File: rtl/note_tone_gen.sv
// note_tone_gen: fetches a MIDI note's half-period from the period ROM and plays it as a 50% square wave.
// Optional feature macro NOTE_TONE_OCT_EN adds oct_down[1:0], shifting the loaded half-period left with saturation.
module note_tone_gen #(
  parameter int unsigned PRESCALE = 16,
  parameter int unsigned ROM_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  note,
  input  logic        note_valid,
  output logic        note_ready,
  input  logic        note_off,
  output logic [6:0]  rom_ad,
  output logic        rom_ce,
  output logic        rom_oce,
  input  logic [15:0] rom_dout,
`ifdef NOTE_TONE_OCT_EN
  input  logic [1:0]  oct_down,
`endif
  output logic        tone,
  output logic        tone_active
);

  localparam int unsigned DW = 16;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned WW = 2;
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(ROM_LAT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_PLAY
  } state_t;

  state_t          state_q, state_d;
  logic            take_c;
  logic [DW-1:0]   hp_load_c;
  logic [DW-1:0]   hp_reg;
  logic [DW-1:0]   hp_cnt;
  logic [PW-1:0]   pre_cnt;
  logic            tick_q;
  logic [WW-1:0]   wait_cnt;

  assign rom_oce = 1'b1;

`ifdef NOTE_TONE_OCT_EN
  logic [DW+2:0] shifted_c;
  assign shifted_c = {3'b000, rom_dout} << oct_down;
  assign hp_load_c = (|shifted_c[DW+2:DW]) ? '1 : shifted_c[DW-1:0];
`else
  assign hp_load_c = rom_dout;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state; note_off overrides everything, including a same-cycle transfer
  always_comb begin
    state_d = state_q;
    take_c  = 1'b0;
    case (state_q)
      S_IDLE, S_PLAY: begin
        if (note_valid && note_ready) begin
          state_d = S_FETCH;
          take_c  = 1'b1;
        end
      end
      S_FETCH: state_d = (ROM_LAT > 1) ? S_WAIT : S_LOAD;
      S_WAIT:  if (wait_cnt == WAIT_LAST) state_d = S_LOAD;
      S_LOAD:  state_d = (hp_load_c == '0) ? S_IDLE : S_PLAY;
      default: state_d = S_IDLE;
    endcase
    if (note_off) begin
      state_d = S_IDLE;
      take_c  = 1'b0;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      note_ready  <= 1'b0;
      tone_active <= 1'b0;
      tone        <= 1'b0;
      rom_ce      <= 1'b0;
      rom_ad      <= '0;
      hp_reg      <= '0;
      hp_cnt      <= '0;
      pre_cnt     <= '0;
      tick_q      <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      note_ready  <= (state_d == S_IDLE) || (state_d == S_PLAY);
      tone_active <= (state_d == S_PLAY);
      rom_ce      <= take_c;
      if (take_c) rom_ad <= note;
      wait_cnt    <= (state_q == S_WAIT) ? wait_cnt + WW'(1) : '0;

      if (note_off) begin
        tone   <= 1'b0;
        tick_q <= 1'b0;
      end else if (state_q == S_LOAD) begin
        hp_reg  <= hp_load_c;
        hp_cnt  <= '0;
        pre_cnt <= '0;
        tick_q  <= 1'b0;
        if (hp_load_c == '0) tone <= 1'b0;
      end else if ((state_q == S_PLAY) && !take_c) begin
        // Registered tick keeps accept-to-first-toggle at 2+ROM_LAT+hp*PRESCALE
        pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
        tick_q  <= (pre_cnt == PRE_LAST);
        if (tick_q) begin
          if (hp_cnt == hp_reg - DW'(1)) begin
            hp_cnt <= '0;
            tone   <= ~tone;
          end else begin
            hp_cnt <= hp_cnt + DW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_note_tone_gen.sv
// Self-checking bench for note_tone_gen: directed scenarios plus random traffic against a behavioural model.
// Exercises the NOTE_TONE_OCT_EN port and scenario when that macro is defined.
module tb_note_tone_gen;

  localparam int PRESCALE = 1;
  localparam int ROM_LAT  = 1;
  localparam int M_IDLE = 0, M_BUSY = 1, M_PLAY = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  note = '0;
  logic        note_valid = 1'b0;
  logic        note_ready;
  logic        note_off = 1'b0;
  logic [6:0]  rom_ad;
  logic        rom_ce;
  logic        rom_oce;
  logic [15:0] rom_dout;
  logic        tone;
  logic        tone_active;
`ifdef NOTE_TONE_OCT_EN
  logic [1:0]  oct_down = 2'd0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic started = 1'b0;

  always #5 clk = ~clk;

  note_tone_gen #(.PRESCALE(PRESCALE), .ROM_LAT(ROM_LAT)) dut (
    .clk(clk),
    .reset(reset),
    .note(note),
    .note_valid(note_valid),
    .note_ready(note_ready),
    .note_off(note_off),
    .rom_ad(rom_ad),
    .rom_ce(rom_ce),
    .rom_oce(rom_oce),
    .rom_dout(rom_dout),
`ifdef NOTE_TONE_OCT_EN
    .oct_down(oct_down),
`endif
    .tone(tone),
    .tone_active(tone_active)
  );

  // Period ROM with ROM_LAT-cycle synchronous read
  logic [15:0] mem [128];
  logic [15:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    if (rom_ce) rom_pipe[0] <= mem[rom_ad];
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_dout = rom_pipe[ROM_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int hp_of(input logic [6:0] a);
    int v;
    v = int'(mem[a]);
`ifdef NOTE_TONE_OCT_EN
    v = v << oct_down;
    if (v > 65535) v = 65535;
`endif
    return v;
  endfunction

  // Behavioural model: tone toggles at fixed arithmetic offsets from the load edge
  int         m_mode = M_IDLE;
  int         m_hp = 0, m_load = 0, m_acc = 0;
  logic       m_tone = 1'b0, m_active = 1'b0, m_ce = 1'b0, m_ready = 1'b0;
  logic [6:0] m_ad = '0;

  always @(posedge clk) begin
    int t, mode, hp, ld, ac, k;
    logic tn, act, ce, rdy;
    logic [6:0] ad;
    t = cyc + 1;
    mode = m_mode; hp = m_hp; ld = m_load; ac = m_acc;
    tn = m_tone; act = m_active; ad = m_ad; ce = 1'b0; rdy = m_ready;
    if (reset) begin
      mode = M_IDLE; tn = 1'b0; act = 1'b0; ad = '0; rdy = 1'b0;
    end else begin
      if (note_off) begin
        mode = M_IDLE; tn = 1'b0; act = 1'b0;
      end else if (note_valid && m_ready) begin
        mode = M_BUSY; ac = t; ad = note; ce = 1'b1; act = 1'b0;
      end else if (mode == M_BUSY) begin
        if (t == ac + 1 + ROM_LAT) begin
          hp = hp_of(ad);
          if (hp == 0) begin
            mode = M_IDLE; tn = 1'b0;
          end else begin
            mode = M_PLAY; ld = t; act = 1'b1;
          end
        end
      end else if (mode == M_PLAY) begin
        k = t - ld - 1;
        if (k > 0 && (k % (hp * PRESCALE)) == 0) tn = ~tn;
      end
      rdy = (mode != M_BUSY);
    end
    cyc <= t;
    m_mode <= mode; m_hp <= hp; m_load <= ld; m_acc <= ac;
    m_tone <= tn; m_active <= act; m_ad <= ad; m_ce <= ce; m_ready <= rdy;
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      check("tone", 32'(tone), 32'(m_tone));
      check("tone_active", 32'(tone_active), 32'(m_active));
      check("note_ready", 32'(note_ready), 32'(m_ready));
      check("rom_ce", 32'(rom_ce), 32'(m_ce));
      check("rom_ad", 32'(rom_ad), 32'(m_ad));
      check("rom_oce", 32'(rom_oce), 32'd1);
    end
  end

  // Edge numbers at which the DUT tone changed
  int   toggle_q[$];
  logic prev_tone = 1'b0;
  always @(negedge clk) begin
    if (started && tone !== prev_tone) toggle_q.push_back(cyc);
    prev_tone <= tone;
  end

  function automatic int tq(input int i);
    return (toggle_q.size() > i) ? toggle_q[i] : -1;
  endfunction

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] n);
    nstep();
    note = n;
    note_valid = 1'b1;
    nstep();
    note_valid = 1'b0;
  endtask

  task automatic wait_toggles(input int n, input int budget, input string name);
    int k = 0;
    while (toggle_q.size() < n && k < budget) begin
      nstep();
      k++;
    end
    check(name, 32'(toggle_q.size() >= n), 32'd1);
  endtask

  initial begin
    int acc0, low_cnt;
    logic lvl;
    for (int n = 0; n < 128; n++) mem[n] = 16'((n * 5) % 23);
    mem[0]   = 16'h17E4;
    mem[127] = 16'h0004;
    mem[5]   = 16'h0000;

    // Reset
    nstep();
    started = 1'b1;
    nstep();
    check("rst_tone", 32'(tone), 32'd0);
    check("rst_active", 32'(tone_active), 32'd0);
    check("rst_ce", 32'(rom_ce), 32'd0);
    check("rst_ready", 32'(note_ready), 32'd0);
    nstep();
    reset = 1'b0;
    nstep();
    check("ready_after_rst", 32'(note_ready), 32'd1);

    // Note 127: half-period 4
    toggle_q.delete();
    send(7'd127);
    check("n127_ce", 32'(rom_ce), 32'd1);
    check("n127_ad", 32'(rom_ad), 32'd127);
    acc0 = m_acc;
    nstep();
    check("n127_ce_drop", 32'(rom_ce), 32'd0);
    wait_toggles(2, 60, "n127_toggles");
    check("n127_first", 32'(tq(0) - acc0), 32'(2 + ROM_LAT + 4));
    check("n127_period", 32'(tq(1) - tq(0)), 32'd4);

    // Retrigger to note 0 while playing: level frozen until the new period runs
    nstep();
    lvl = tone;
    note = 7'd0;
    note_valid = 1'b1;
    nstep();
    note_valid = 1'b0;
    toggle_q.delete();
    acc0 = m_acc;
    check("retrig_tone_frozen", 32'(tone), 32'(lvl));
    low_cnt = 0;
    while (note_ready !== 1'b1 && low_cnt < 10) begin
      low_cnt++;
      nstep();
    end
    check("retrig_ready_low", 32'(low_cnt), 32'(ROM_LAT + 1));
    check("retrig_tone_held", 32'(tone), 32'(lvl));
    wait_toggles(2, 12400, "n0_toggles");
    check("n0_first", 32'(tq(0) - acc0), 32'(2 + ROM_LAT + 6116));
    check("n0_period", 32'(tq(1) - tq(0)), 32'd6116);

    // Zero ROM word: silent entry
    send(7'd5);
    toggle_q.delete();
    repeat (3) nstep();
    check("silent_tone", 32'(tone), 32'd0);
    check("silent_active", 32'(tone_active), 32'd0);
    check("silent_ready", 32'(note_ready), 32'd1);
    repeat (1000) nstep();
    check("silent_no_toggle", 32'(toggle_q.size()), 32'd0);

    // note_off mid-fetch
    nstep();
    note = 7'd127;
    note_valid = 1'b1;
    nstep();
    note_valid = 1'b0;
    note_off = 1'b1;
    check("off_fetch_ce", 32'(rom_ce), 32'd1);
    nstep();
    note_off = 1'b0;
    check("off_tone", 32'(tone), 32'd0);
    check("off_active", 32'(tone_active), 32'd0);
    check("off_ready", 32'(note_ready), 32'd1);
    toggle_q.delete();
    repeat (20) nstep();
    check("off_no_load", 32'(tone_active), 32'd0);
    check("off_no_toggle", 32'(toggle_q.size()), 32'd0);

    // note_off and transfer together: no fetch
    note = 7'd127;
    note_valid = 1'b1;
    note_off = 1'b1;
    nstep();
    note_valid = 1'b0;
    note_off = 1'b0;
    check("both_no_ce", 32'(rom_ce), 32'd0);
    check("both_ready", 32'(note_ready), 32'd1);
    repeat (20) nstep();
    check("both_no_play", 32'(tone_active), 32'd0);
    check("both_no_toggle", 32'(toggle_q.size()), 32'd0);

`ifdef NOTE_TONE_OCT_EN
    oct_down = 2'd2;
    toggle_q.delete();
    send(7'd127);
    acc0 = m_acc;
    wait_toggles(1, 60, "oct127_toggle");
    check("oct127_first", 32'(tq(0) - acc0), 32'(2 + ROM_LAT + 16));
    mem[10] = 16'hC000;
    send(7'd10);
    toggle_q.delete();
    acc0 = m_acc;
    wait_toggles(1, 66000, "oct_sat_toggle");
    check("oct_sat_first", 32'(tq(0) - acc0), 32'(2 + ROM_LAT + 65535));
    mem[10] = 16'((10 * 5) % 23);
    note_off = 1'b1;
    nstep();
    note_off = 1'b0;
    oct_down = 2'd0;
`endif

    // Random traffic checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      nstep();
      note       = 7'($urandom_range(0, 127));
      note_valid = ($urandom_range(0, 3) == 0);
      note_off   = ($urandom_range(0, 39) == 0);
      reset      = ($urandom_range(0, 599) == 0);
`ifdef NOTE_TONE_OCT_EN
      oct_down   = 2'($urandom_range(0, 3));
`endif
    end
    nstep();
    note_valid = 1'b0;
    note_off = 1'b0;
    reset = 1'b0;
    repeat (5) nstep();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
